// File: rtl/nonce_batch_scheduler.sv
// Nonce batch scheduler: hands BATCH-nonce jobs to a pool of hash cores and tracks the best hit.
// Optional SCHED_STATS_EN adds stat_jobs / stat_cycles counters.
module nonce_batch_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int BATCH     = 16,
    parameter int LANE_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [31:0]                   nonce_first,
    input  logic [31:0]                   nonce_last,
    input  logic [31:0]                   target,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [31:0]                   found_nonce,
    output logic [31:0]                   found_h0,
    output logic [NUM_CORES-1:0]          core_start,
    output logic [NUM_CORES*32-1:0]       core_base,
    input  logic [NUM_CORES-1:0]          core_done,
    input  logic [NUM_CORES*32-1:0]       core_best_h0,
    input  logic [NUM_CORES*LANE_W-1:0]   core_best_lane
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]                   stat_jobs,
    output logic [31:0]                   stat_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t               state;
    logic [32:0]          next_nonce;
    logic [31:0]          last_q;
    logic [31:0]          tgt_q;
    logic [NUM_CORES-1:0] cbusy;
    logic [31:0]          base_q [NUM_CORES];

    logic [NUM_CORES-1:0] pick;
    logic                 any_idle;
    logic                 stop;
    logic                 disp;
    logic                 hit_v;
    logic [31:0]          hit_h0;
    logic [31:0]          hit_n;
    logic                 take_hit;

    // Ordering shared by per-cycle selection and merge: lower h0, then lower nonce
    function automatic logic better(input logic [31:0] ha, input logic [31:0] na,
                                    input logic [31:0] hb, input logic [31:0] nb);
        return (ha < hb) || ((ha == hb) && (na < nb));
    endfunction

    always_comb begin
        pick     = '0;
        any_idle = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!cbusy[i] && !any_idle) begin
                pick[i]  = 1'b1;
                any_idle = 1'b1;
            end
        end
        stop = (next_nonce > {1'b0, last_q}) || found || abort;
        disp = (state == RUN) && !stop && any_idle;
    end

    always_comb begin
        logic [31:0] cand;
        logic [31:0] h0;
        logic        ok;
        hit_v  = 1'b0;
        hit_h0 = '0;
        hit_n  = '0;
        cand   = '0;
        h0     = '0;
        ok     = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            h0   = core_best_h0[i*32 +: 32];
            cand = base_q[i] + 32'(core_best_lane[i*LANE_W +: LANE_W]);
            ok   = ((state == RUN) || (state == DRAIN)) && core_done[i] && cbusy[i]
                   && (h0 < tgt_q) && (cand <= last_q);
            if (ok && (!hit_v || better(h0, cand, hit_h0, hit_n))) begin
                hit_v  = 1'b1;
                hit_h0 = h0;
                hit_n  = cand;
            end
        end
        take_hit = hit_v && (!found || better(hit_h0, hit_n, found_h0, found_nonce));
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) core_base[i*32 +: 32] = base_q[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            next_nonce  <= '0;
            last_q      <= '0;
            tgt_q       <= '0;
            cbusy       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_h0    <= '0;
            core_start  <= '0;
            for (int i = 0; i < NUM_CORES; i++) base_q[i] <= '0;
`ifdef SCHED_STATS_EN
            stat_jobs   <= '0;
            stat_cycles <= '0;
`endif
        end else begin
            core_start <= '0;
            done       <= 1'b0;
            // A core finishing this cycle is not in pick, so it waits a cycle
            cbusy      <= (cbusy & ~core_done) | (disp ? pick : '0);
            if (take_hit) begin
                found       <= 1'b1;
                found_nonce <= hit_n;
                found_h0    <= hit_h0;
            end
            if (disp) begin
                core_start <= pick;
                next_nonce <= next_nonce + 33'(BATCH);
                for (int i = 0; i < NUM_CORES; i++)
                    if (pick[i]) base_q[i] <= next_nonce[31:0];
            end
`ifdef SCHED_STATS_EN
            if (busy) stat_cycles <= stat_cycles + 32'd1;
            if (disp) stat_jobs <= stat_jobs + 32'd1;
`endif
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        next_nonce  <= {1'b0, nonce_first};
                        last_q      <= nonce_last;
                        tgt_q       <= target;
                        found       <= 1'b0;
                        found_nonce <= '0;
                        found_h0    <= '0;
`ifdef SCHED_STATS_EN
                        stat_jobs   <= '0;
                        stat_cycles <= '0;
`endif
                    end
                end
                RUN: begin
                    if (stop) state <= DRAIN;
                end
                DRAIN: begin
                    if (cbusy == '0) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nonce_batch_scheduler.md
Name: nonce_batch_scheduler

Overview:
- Sequences a pool of NUM_CORES parallel double-SHA256 hash cores across a nonce range, one BATCH-nonce job per core start.
- Hands out batch base nonces by lowest-index-idle-core priority and collects each core's best final-H0 result.
- Compares each result against a 32-bit target and reports the winning nonce.
- Sits between the host/control register block and the hash core array.

Parameters:
NUM_CORES, 4, number of hash cores scheduled
BATCH, 16, nonces per core job (core lanes); power of two
LANE_W, 4, width of core lane index, log2(BATCH)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start  input  1  begin search; sampled only in IDLE
abort  input  1  stop issuing new jobs, drain outstanding, finish
nonce_first  input  32  first nonce of range, sampled on start
nonce_last  input  32  last nonce of range, inclusive, sampled on start
target  input  32  hit if core H0 < target (unsigned), sampled on start
busy  output  1  high from start accept until done pulse
done  output  1  one-cycle pulse at search end
found  output  1  a valid hit was recorded; held until next start
found_nonce  output  32  nonce of best hit
found_h0  output  32  H0 of best hit
core_start  output  NUM_CORES  one-cycle start pulse per core
core_base  output  NUM_CORES*32  per-core base nonce, stable while that core is busy
core_done  input  NUM_CORES  one-cycle completion pulse per core
core_best_h0  input  NUM_CORES*32  core's minimum final H0; valid with core_done
core_best_lane  input  NUM_CORES*LANE_W  lane of that minimum; valid with core_done

Behaviour:
- Reset: state IDLE; busy=0, done=0, found=0, found_nonce=0, found_h0=0, core_start=0, core_base=0; all core-busy flags cleared. Reset mid-search abandons outstanding jobs; later core_done pulses from those jobs are ignored in IDLE.
- States: IDLE -> RUN on start (busy=1 next cycle; next_nonce = {1'b0, nonce_first}, found cleared). RUN -> DRAIN when no further jobs will issue: next_nonce > nonce_last, or found, or abort seen. DRAIN -> FINISH when all core-busy flags are 0. FINISH: done=1 for one cycle, busy=0, -> IDLE.
- next_nonce is 33 bits, so nonce_last=32'hFFFFFFFF terminates without wrap.
- Dispatch in RUN: at most one job per cycle, to the lowest-index idle core.
  - core_start[i]=1 for one cycle; core_base[i]=next_nonce[31:0] registered on the same edge; busy flag set; next_nonce += BATCH.
  - core_base[i] holds until that core's next dispatch.
- Completion: core_done[i] clears busy[i] on that edge. The core becomes eligible for dispatch the following cycle, never the same cycle.
- Hit rule: candidate nonce = core_base[i] + core_best_lane[i] (32-bit).
  - Valid only if core_best_h0 < target AND candidate <= nonce_last; lanes beyond nonce_last in the final partial batch are discarded.
- Multiple core_done in one cycle: all are evaluated that cycle.
  - Best = smallest h0; tie -> smallest nonce.
  - Merged with the stored hit using the same ordering.
- Hits arriving during DRAIN are still merged. The first hit stops dispatch, but outstanding jobs may improve found_h0.
- abort is level-sampled in RUN; abort in IDLE/DRAIN/FINISH has no effect. start while busy is ignored.
- nonce_first > nonce_last: RUN issues no jobs, goes DRAIN -> FINISH; done pulses 3 cycles after start, found=0.
- Latency start -> first core_start: 2 cycles (start edge enters RUN; dispatch on next edge).

Optional Feature:
- Macro SCHED_STATS_EN.
- Defined: adds outputs stat_jobs[31:0] (jobs issued) and stat_cycles[31:0] (cycles busy=1), both cleared on start and frozen after done.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- nonce_first=0, nonce_last=63, target=0, NUM_CORES=4, cores done after 100 cycles -> exactly 4 core_start pulses; bases 0,16,32,48 to cores 0..3; found=0; done pulses once.
- Same range, core 2 returns h0=32'h00001234, lane 5, target=32'h00010000 -> found=1, found_nonce=37, found_h0=32'h00001234.
- Cores 1 and 3 done in the same cycle with h0 32'h00000500 (lane 0) and 32'h00000500 (lane 2) -> found_nonce=16, tie broken to the smaller nonce.
- nonce_first=32'hFFFFFFF0, nonce_last=32'hFFFFFFFF -> one job, base 32'hFFFFFFF0, no second dispatch, terminates without wrap.
- nonce_last=9, single job; core returns lane 12 with h0 below target -> hit discarded, found=0.
- abort asserted after 2 dispatches of a 256-nonce range -> no further core_start; done only after both outstanding core_done; with SCHED_STATS_EN, stat_jobs=2.
